bn_coef_loader: RTL and testbench
=================================

Name: bn_coef_loader

Overview:
- Writer side of the per-channel batch-norm coefficient interface (a = scale, b = bias) consumed by the BN+ReLU fixed-point stage.
- Accepts a serial valid/ready stream of coefficient words and assembles them into a shadow bank.
- Commits the shadow bank atomically to the active parallel a/b buses only when the downstream pipeline signals that a swap is safe.
- Sits between the config/DMA word stream and each BN+ReLU instance.

Parameters:
- NO_CH, 10, number of channels.
- BW, 12, activation width of the BN stage.
- R_SHIFT, 6, fractional shift of the BN stage. Coefficient width CW = BW+R_SHIFT, a localparam.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_vld  in  1  coefficient word valid.
- cfg_rdy  out  1  loader can accept a word.
- cfg_data  in  CW  coefficient word, two's complement.
- cfg_last  in  1  marks the final word of a set.
- commit_ok  in  1  downstream idle; a bank swap is permitted.
- a  out  NO_CH x CW  active scale bank, packed [NO_CH-1:0][CW-1:0].
- b  out  NO_CH x CW  active bias bank, same packing.
- coef_vld  out  1  active bank holds a complete committed set.
- err  out  1  sticky framing error.

Behaviour:
- Transfer occurs on a clk edge when cfg_vld && cfg_rdy.
- Set format: exactly 2*NO_CH words, in the order a[0]..a[NO_CH-1], then b[0]..b[NO_CH-1]. cfg_last is high on word 2*NO_CH-1 only.
- Word counter wc runs 0..2*NO_CH-1. Word wc goes to shadow_a[wc] if wc<NO_CH, else to shadow_b[wc-NO_CH].
- FSM states: S_LOAD, S_PEND, S_SKIP.
  - S_LOAD: cfg_rdy=1.
    - Accepted word with wc==2*NO_CH-1 and cfg_last=1 goes to S_PEND, wc<=0.
    - cfg_last=1 with wc<2*NO_CH-1: err<=1, wc<=0, stay in S_LOAD, shadow discarded.
    - wc==2*NO_CH-1 with cfg_last=0: err<=1, go to S_SKIP.
  - S_PEND: cfg_rdy=0. When commit_ok=1: a<=shadow_a, b<=shadow_b, coef_vld<=1, go to S_LOAD.
  - S_SKIP: cfg_rdy=1. Words are discarded until an accepted word has cfg_last=1, then go to S_LOAD with wc=0.
- cfg_rdy is a combinational decode of state, forced to 0 while rst is high.
- Latency: last word accepted at edge T puts the FSM in S_PEND for the following cycle. If commit_ok is high in that cycle, a/b/coef_vld change at edge T+1 (one cycle after acceptance).
- commit_ok is ignored outside S_PEND. a/b never change except at a commit.
- Shadow writes never disturb a/b, so the BN stage always sees a coherent set.
- Reset, including mid-load:
  - state<=S_LOAD, wc<=0, a<=0, b<=0, coef_vld<=0, err<=0.
  - Shadow contents are don't-care.
- err clears only on rst.
- Back-to-back sets: the next set's first word is accepted the cycle after the commit edge.

Optional Feature:
- Macro BN_COEF_READBACK_EN.
- Defined: adds ports rd_idx in [$clog2(2*NO_CH)-1:0] and rd_data out CW.
  - rd_data is registered, one-cycle latency, and reads the active bank with the same index mapping as the load order.
  - Out-of-range rd_idx returns 0. rd_data resets to 0.
- Undefined: those ports and the read logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package bn_pkg holds:
  - function coef_w(BW, R_SHIFT) returning BW+R_SHIFT;
  - enum bn_ld_state_t {S_LOAD, S_PEND, S_SKIP};
  - function wc_w(NO_CH) returning $clog2(2*NO_CH).
- One sub-module, bn_coef_bank: NO_CH x CW shadow/active register pair with write-enable/index and a commit strobe.
- The FSM and counter stay in the top module.

Test Plan (NO_CH=10, CW=18):
- Words 1..20, last on word 20, commit_ok=1 → a[0..9]=1..10, b[0..9]=11..20, coef_vld=1 one cycle after the last is accepted, err=0.
- Same load with commit_ok=0 → cfg_rdy=0 and a/b hold their old values. commit_ok raised 5 cycles later → a/b update at the next edge, and cfg_rdy returns to 1 the cycle after that.
- cfg_last on word 7 → err=1, a/b unchanged. A following correct set of values -1..-20 commits normally and err stays 1.
- 20 words with no last, then 3 junk words with last on the 3rd → err=1 and all 23 are discarded. The next 20-word set loads correctly.
- rst pulsed after word 12 → a=b=0, coef_vld=0, err=0. The next set starts at a[0].
- Random cfg_vld gaps, plus (if BN_COEF_READBACK_EN) rd_idx=13 after commit → rd_data=14 one cycle later.

Source files
------------

// File: rtl/bn_pkg.sv
// bn_pkg: shared types and width helpers for the batch-norm coefficient loader.
//   coef_w(bw, r_shift) : coefficient word width (activation width + fraction bits)
//   wc_w(no_ch)         : width of the word counter / word index for a 2*no_ch set
//   bn_ld_state_t       : loader FSM states
package bn_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,  // accepting words into the shadow bank
    S_PEND = 2'd1,  // full set held, waiting for a safe swap
    S_SKIP = 2'd2   // framing error, dropping words until cfg_last
  } bn_ld_state_t;

  function automatic int coef_w(input int bw, input int r_shift);
    return bw + r_shift;
  endfunction

  function automatic int wc_w(input int no_ch);
    return $clog2(2 * no_ch);
  endfunction

endpackage

// File: rtl/bn_coef_bank.sv
// bn_coef_bank: shadow/active register pair for one batch-norm coefficient set.
// Entries 0..NO_CH-1 hold scale (a), entries NO_CH..2*NO_CH-1 hold bias (b),
// which is exactly the load order, so the word counter is the write index.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears active bank)
//   wr_en, wr_idx,
//   wr_data           shadow write port
//   commit            copy the whole shadow bank into the active bank
//   active            active bank, registered
module bn_coef_bank #(
  parameter int NO_CH = 10,
  parameter int CW    = 18,
  parameter int WW    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WW-1:0]                 wr_idx,
  input  logic [CW-1:0]                 wr_data,
  input  logic                          commit,
  output logic [2*NO_CH-1:0][CW-1:0]    active
);

  // Shadow contents are don't-care after reset, so they carry no reset.
  logic [2*NO_CH-1:0][CW-1:0] shadow_r;

  // Shadow bank write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_r[wr_idx] <= wr_data;
    end
  end

  // Active bank: only ever changes as a whole, on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow_r;
    end
  end

endmodule

// File: rtl/bn_coef_loader.sv
// bn_coef_loader: assembles a serial valid/ready stream of batch-norm
// coefficient words (a[0..NO_CH-1] then b[0..NO_CH-1], cfg_last on the final
// word) into a shadow bank and swaps it atomically onto the a/b buses when
// commit_ok says the downstream BN+ReLU stage is idle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_vld/cfg_rdy      word handshake; cfg_data word, cfg_last end of set
//   commit_ok            downstream permits a bank swap
//   a, b                 active scale / bias banks [NO_CH-1:0][CW-1:0]
//   coef_vld             active bank holds a complete committed set
//   err                  sticky framing error (cleared only by rst)
// Optional (macro BN_COEF_READBACK_EN):
//   rd_idx, rd_data      registered readback of the active bank, load-order index
module bn_coef_loader
  import bn_pkg::*;
#(
  parameter  int NO_CH   = 10,
  parameter  int BW      = 12,
  parameter  int R_SHIFT = 6,
  localparam int CW      = coef_w(BW, R_SHIFT),
  localparam int WW      = wc_w(NO_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_vld,
  output logic                     cfg_rdy,
  input  logic [CW-1:0]            cfg_data,
  input  logic                     cfg_last,
  input  logic                     commit_ok,
  output logic [NO_CH-1:0][CW-1:0] a,
  output logic [NO_CH-1:0][CW-1:0] b,
  output logic                     coef_vld,
  output logic                     err
`ifdef BN_COEF_READBACK_EN
  ,
  input  logic [WW-1:0]            rd_idx,
  output logic [CW-1:0]            rd_data
`endif
);

  localparam logic [WW-1:0] WC_MAX = WW'(2 * NO_CH - 1);
  localparam logic [WW-1:0] WC_ONE = {{(WW-1){1'b0}}, 1'b1};

  bn_ld_state_t               state_r, state_nxt_s;
  logic [WW-1:0]              wc_r, wc_nxt_s;
  logic                       err_r, err_nxt_s;
  logic                       coef_vld_r, coef_vld_nxt_s;
  logic                       wr_en_s, commit_s, xfer_s, wc_last_s;
  logic [2*NO_CH-1:0][CW-1:0] active_s;

  assign cfg_rdy   = ~rst & ((state_r == S_LOAD) | (state_r == S_SKIP));
  assign xfer_s    = cfg_vld & cfg_rdy;
  assign wc_last_s = (wc_r == WC_MAX);

  assign a        = active_s[NO_CH-1:0];
  assign b        = active_s[2*NO_CH-1:NO_CH];
  assign coef_vld = coef_vld_r;
  assign err      = err_r;

  bn_coef_bank #(
    .NO_CH (NO_CH),
    .CW    (CW),
    .WW    (WW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_idx  (wc_r),
    .wr_data (cfg_data),
    .commit  (commit_s),
    .active  (active_s)
  );

  // Next-state, counter, error and bank-control decode.
  always_comb begin
    state_nxt_s    = state_r;
    wc_nxt_s       = wc_r;
    err_nxt_s      = err_r;
    coef_vld_nxt_s = coef_vld_r;
    wr_en_s        = 1'b0;
    commit_s       = 1'b0;
    case (state_r)
      S_LOAD: begin
        if (xfer_s) begin
          // A word written before a framing error is harmless: the next set
          // overwrites every shadow entry before it can be committed.
          wr_en_s = 1'b1;
          if (cfg_last && wc_last_s) begin
            state_nxt_s = S_PEND;
            wc_nxt_s    = '0;
          end else if (cfg_last) begin
            err_nxt_s = 1'b1;
            wc_nxt_s  = '0;
          end else if (wc_last_s) begin
            err_nxt_s   = 1'b1;
            wc_nxt_s    = '0;
            state_nxt_s = S_SKIP;
          end else begin
            wc_nxt_s = wc_r + WC_ONE;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      S_PEND: begin
        if (commit_ok) begin
          commit_s       = 1'b1;
          coef_vld_nxt_s = 1'b1;
          state_nxt_s    = S_LOAD;
        end else begin
          commit_s = 1'b0;
        end
      end
      S_SKIP: begin
        if (xfer_s && cfg_last) begin
          state_nxt_s = S_LOAD;
          wc_nxt_s    = '0;
        end else begin
          state_nxt_s = S_SKIP;
        end
      end
      default: begin
        state_nxt_s = S_LOAD;
        wc_nxt_s    = '0;
      end
    endcase
  end

  // FSM state, word counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_LOAD;
      wc_r       <= '0;
      err_r      <= 1'b0;
      coef_vld_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wc_r       <= wc_nxt_s;
      err_r      <= err_nxt_s;
      coef_vld_r <= coef_vld_nxt_s;
    end
  end

`ifdef BN_COEF_READBACK_EN
  // Registered readback of the active bank; indices past the set read as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_idx <= WC_MAX) begin
      rd_data <= active_s[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_bn_coef_loader.sv
// Self-checking bench for bn_coef_loader (NO_CH=10, CW=18). Expected banks are
// queued when a set is driven; a monitor pops and compares whenever the
// active a/b buses change. Directed checks cover latency, hold, framing
// errors and reset.
module tb_bn_coef_loader;
  import bn_pkg::*;

  localparam int NO_CH = 10;
  localparam int CW    = 18;
  localparam int WW    = 5;
  localparam int TW    = 2 * NO_CH * CW;

  typedef logic [2*NO_CH-1:0][CW-1:0] set_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_vld;
  logic                     cfg_rdy;
  logic [CW-1:0]            cfg_data;
  logic                     cfg_last;
  logic                     commit_ok;
  logic [NO_CH-1:0][CW-1:0] a;
  logic [NO_CH-1:0][CW-1:0] b;
  logic                     coef_vld;
  logic                     err;
`ifdef BN_COEF_READBACK_EN
  logic [WW-1:0]            rd_idx;
  logic [CW-1:0]            rd_data;
`endif

  int   errors = 0;
  int   checks = 0;
  set_t exp_q[$];
  set_t cur;
  set_t prev;
  bit   mon_en = 1'b0;

  bn_coef_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_vld   (cfg_vld),
    .cfg_rdy   (cfg_rdy),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .commit_ok (commit_ok),
    .a         (a),
    .b         (b),
    .coef_vld  (coef_vld),
    .err       (err)
`ifdef BN_COEF_READBACK_EN
    ,
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
`endif
  );

  always #5 clk = ~clk;

  assign cur = {b, a};

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every change of the active banks must be a queued commit.
  always @(negedge clk) begin
    if (mon_en && (cur !== prev)) begin
      if (exp_q.size() > 0) chk("commit", cur, exp_q.pop_front());
      else                  chk("spurious_change", cur, prev);
    end
    prev <= cur;
  end

  function automatic set_t mk_set(input int base);
    set_t s;
    for (int i = 0; i < 2 * NO_CH; i++) s[i] = CW'(base + i);
    return s;
  endfunction

  task automatic send_word(input logic [CW-1:0] d, input logic l);
    int n;
    n = 0;
    cfg_vld  = 1'b1;
    cfg_data = d;
    cfg_last = l;
    while (cfg_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cfg_rdy !== 1'b1) chk("rdy_wait", TW'(cfg_rdy), TW'(1));
    @(posedge clk);
    #1;
    cfg_vld  = 1'b0;
    cfg_last = 1'b0;
  endtask

  task automatic send_set(input set_t w, input int gap_max);
    for (int i = 0; i < 2 * NO_CH; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          @(posedge clk);
          #1;
        end
      end
      send_word(w[i], (i == 2 * NO_CH - 1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", TW'(exp_q.size()), TW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_t s1, s2, s3, s4, s5, s6, sr, zero_s;
    zero_s    = '0;
    rst       = 1'b1;
    cfg_vld   = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    commit_ok = 1'b0;
`ifdef BN_COEF_READBACK_EN
    rd_idx    = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rdy_in_reset", TW'(cfg_rdy), TW'(0));
    rst = 1'b0;
    #1;
    chk("reset_ab", cur, zero_s);
    chk("reset_vld", TW'(coef_vld), TW'(0));
    chk("reset_err", TW'(err), TW'(0));
    chk("reset_rdy", TW'(cfg_rdy), TW'(1));
    mon_en = 1'b1;

    // Basic load, commit one cycle after the last word.
    commit_ok = 1'b1;
    s1 = mk_set(1);
    exp_q.push_back(s1);
    send_set(s1, 0);
    chk("pend_rdy", TW'(cfg_rdy), TW'(0));
    chk("pend_vld", TW'(coef_vld), TW'(0));
    chk("pend_ab", cur, zero_s);
    @(posedge clk);
    #1;
    chk("t1_ab", cur, s1);
    chk("t1_a9", TW'(a[9]), TW'(10));
    chk("t1_b0", TW'(b[0]), TW'(11));
    chk("t1_vld", TW'(coef_vld), TW'(1));
    chk("t1_err", TW'(err), TW'(0));
    chk("t1_rdy", TW'(cfg_rdy), TW'(1));
    wait_drain();
`ifdef BN_COEF_READBACK_EN
    rd_idx = 5'd13;
    @(posedge clk);
    #1;
    chk("rd_13", TW'(rd_data), TW'(14));
    rd_idx = 5'd25;
    @(posedge clk);
    #1;
    chk("rd_oor", TW'(rd_data), TW'(0));
`endif

    // Commit held off by commit_ok.
    commit_ok = 1'b0;
    s2 = mk_set(101);
    exp_q.push_back(s2);
    send_set(s2, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rdy", TW'(cfg_rdy), TW'(0));
      chk("hold_ab", cur, s1);
      @(posedge clk);
      #1;
    end
    commit_ok = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_ab", cur, s2);
    chk("t2_rdy", TW'(cfg_rdy), TW'(1));
    wait_drain();

    // Early cfg_last, then a good negative set; err stays set.
    for (int i = 0; i < 7; i++) send_word(CW'(i + 1), (i == 6));
    chk("early_err", TW'(err), TW'(1));
    chk("early_ab", cur, s2);
    chk("early_rdy", TW'(cfg_rdy), TW'(1));
    for (int i = 0; i < 2 * NO_CH; i++) s3[i] = CW'(-(i + 1));
    exp_q.push_back(s3);
    send_set(s3, 0);
    @(posedge clk);
    #1;
    chk("t3_ab", cur, s3);
    wait_drain();
    chk("t3_err", TW'(err), TW'(1));

    // Reset in the middle of a load.
    s4 = mk_set(301);
    for (int i = 0; i < 12; i++) send_word(s4[i], 1'b0);
    exp_q.push_back(zero_s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_ab", cur, zero_s);
    chk("mid_rst_vld", TW'(coef_vld), TW'(0));
    chk("mid_rst_err", TW'(err), TW'(0));
    wait_drain();
    s5 = mk_set(401);
    exp_q.push_back(s5);
    send_set(s5, 0);
    wait_drain();
    chk("t5_a0", TW'(a[0]), TW'(401));
    chk("t5_vld", TW'(coef_vld), TW'(1));

    // Missing cfg_last: 20 words plus 3 junk words all discarded.
    for (int i = 0; i < 2 * NO_CH; i++) send_word(CW'(500 + i), 1'b0);
    chk("skip_err", TW'(err), TW'(1));
    chk("skip_rdy", TW'(cfg_rdy), TW'(1));
    for (int i = 0; i < 3; i++) send_word(CW'(600 + i), (i == 2));
    repeat (3) @(posedge clk);
    #1;
    chk("skip_ab", cur, s5);
    s6 = mk_set(701);
    exp_q.push_back(s6);
    send_set(s6, 0);
    wait_drain();
    chk("t4_ab", cur, s6);

    // Random gaps on cfg_vld and random commit delay.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2 * NO_CH; i++) sr[i] = CW'($urandom);
      commit_ok = 1'b0;
      exp_q.push_back(sr);
      send_set(sr, 3);
      repeat ($urandom_range(4, 0)) begin
        @(posedge clk);
        #1;
      end
      commit_ok = 1'b1;
      wait_drain();
    end
    chk("final_err", TW'(err), TW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
